// File: rtl/distance_pkg.sv
// Shared types and parameter derivations for the multi-lane KNN distance engine.
package distance_pkg;

  typedef enum logic {
    METRIC_SQ_EUCLID = 1'b0,
    METRIC_MANHATTAN = 1'b1
  } metric_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic int calc_nchunk(input int features, input int lanes);
    return (features + lanes - 1) / lanes;
  endfunction

  // Wide enough that FEATURES worst-case squared differences cannot wrap.
  function automatic int calc_acc_w(input int w, input int features);
    return 2 * w + 2 + clog2(features);
  endfunction

endpackage

// File: rtl/distance_engine_lane.sv
// One distance lane: registered signed difference, then registered square or magnitude.
module dist_lane
  import distance_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             lane_en,
  input  metric_e          metric,
  input  logic [W-1:0]     train,
  input  logic [W-1:0]     query,
  output logic [2*W+1:0]   term
);

  logic signed [W:0]     diff;
  logic signed [2*W+1:0] diff_wide;
  logic signed [2*W+1:0] square;
  logic        [W:0]     magnitude;

  always_comb begin
    diff_wide = (2*W+2)'(diff);
    square    = diff_wide * diff_wide;
    magnitude = diff[W] ? -diff : diff;
  end

  // Masked lanes load a zero difference so they add nothing for either metric.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      term <= '0;
    end else begin
      if (load) begin
        diff <= lane_en ? ($signed({train[W-1], train}) - $signed({query[W-1], query})) : '0;
      end
      term <= (metric == METRIC_MANHATTAN) ? {{(W+1){1'b0}}, magnitude} : $unsigned(square);
    end
  end

endmodule

// File: rtl/distance_engine.sv
// Multi-lane KNN distance engine: streams chunks of a training/query vector pair and
// returns a saturated squared-Euclidean or Manhattan distance with the training label.
module distance_engine
  import distance_pkg::*;
#(
  parameter int FEATURES = 16,
  parameter int W        = 8,
  parameter int LANES    = 4,
  parameter int TYPE_W   = 4,
  parameter int OUT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 metric_sel,
  input  logic                 chunk_valid,
  output logic                 chunk_ready,
  input  logic [W*LANES-1:0]   chunk_train,
  input  logic [W*LANES-1:0]   chunk_query,
  input  logic [TYPE_W-1:0]    chunk_type,
  output logic                 dist_valid,
  input  logic                 dist_ready,
  output logic [OUT_W-1:0]     distance,
  output logic [TYPE_W-1:0]    data_type,
  output logic                 sat,
  output logic                 busy
);

  localparam int NCHUNK     = calc_nchunk(FEATURES, LANES);
  localparam int ACC_W      = calc_acc_w(W, FEATURES);
  localparam int TERM_W     = 2 * W + 2;
  localparam int CNT_W      = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam int LAST_LANES = FEATURES - (NCHUNK - 1) * LANES;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
  localparam logic [ACC_W+OUT_W-1:0] SAT_LIMIT = {{ACC_W{1'b0}}, {OUT_W{1'b1}}};

  state_e             state;
  state_e             state_next;
  metric_e            metric_q;
  logic [CNT_W-1:0]   chunk_cnt;
  logic               drain_cnt;
  logic               s1_valid;
  logic               s2_valid;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   lane_sum;
  logic [TERM_W-1:0]  lane_term [LANES];
  logic               beat;
  logic               last_chunk;

  assign beat       = chunk_valid && chunk_ready;
  assign last_chunk = (chunk_cnt == LAST_CHUNK);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic lane_en;
    if (i < LAST_LANES) begin : g_full
      assign lane_en = 1'b1;
    end else begin : g_tail
      assign lane_en = !last_chunk;
    end

    dist_lane #(.W(W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (beat),
      .lane_en (lane_en),
      .metric  (metric_q),
      .train   (chunk_train[(i+1)*W-1 -: W]),
      .query   (chunk_query[(i+1)*W-1 -: W]),
      .term    (lane_term[i])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + ACC_W'(lane_term[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Two DRAIN cycles cover the difference and term stages behind the last beat.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (beat && last_chunk) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_next = ST_OUT;
      ST_OUT:   if (dist_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      metric_q  <= METRIC_SQ_EUCLID;
      chunk_cnt <= '0;
      drain_cnt <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      acc       <= '0;
      data_type <= '0;
    end else begin
      s1_valid  <= beat;
      s2_valid  <= s1_valid;
      drain_cnt <= (state == ST_DRAIN) ? !drain_cnt : 1'b0;
      if (state == ST_IDLE && start) begin
        acc       <= '0;
        chunk_cnt <= '0;
        metric_q  <= metric_e'(metric_sel);
      end else if (s2_valid) begin
        acc <= acc + lane_sum;
      end
      if (beat) begin
        chunk_cnt <= chunk_cnt + CNT_W'(1);
        if (last_chunk) data_type <= chunk_type;
      end
    end
  end

  // The accumulator is frozen in OUT, so the combinational result stays stable.
  assign sat         = {{OUT_W{1'b0}}, acc} > SAT_LIMIT;
  assign distance    = sat ? {OUT_W{1'b1}} : OUT_W'(acc);
  assign chunk_ready = (state == ST_RUN);
  assign dist_valid  = (state == ST_OUT);
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_distance_engine.sv
// Scoreboard bench for distance_engine: a 16-feature instance and a 10-feature instance
// (masked tail lanes) driven with directed and random vectors against a vector-level model.
module tb_distance_engine;

  typedef struct packed {
    logic [15:0] distance;
    logic        sat;
    logic [3:0]  data_type;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start       [2];
  logic        metric_sel  [2];
  logic        chunk_valid [2];
  logic        chunk_ready [2];
  logic [31:0] chunk_train [2];
  logic [31:0] chunk_query [2];
  logic [3:0]  chunk_type  [2];
  logic        dist_valid  [2];
  logic        dist_ready  [2];
  logic [15:0] distance    [2];
  logic [3:0]  data_type   [2];
  logic        sat         [2];
  logic        busy        [2];

  int   checks;
  int   errors;
  int   ready_delay;
  int   wait_cnt     [2];
  int   train_vec    [16];
  int   query_vec    [16];
  exp_t exp_q        [2][$];
  bit   hold_pending [2];
  exp_t held         [2];

  distance_engine u_dut16 (
    .clk(clk), .rst(rst), .start(start[0]), .metric_sel(metric_sel[0]),
    .chunk_valid(chunk_valid[0]), .chunk_ready(chunk_ready[0]),
    .chunk_train(chunk_train[0]), .chunk_query(chunk_query[0]), .chunk_type(chunk_type[0]),
    .dist_valid(dist_valid[0]), .dist_ready(dist_ready[0]), .distance(distance[0]),
    .data_type(data_type[0]), .sat(sat[0]), .busy(busy[0])
  );

  distance_engine #(.FEATURES(10)) u_dut10 (
    .clk(clk), .rst(rst), .start(start[1]), .metric_sel(metric_sel[1]),
    .chunk_valid(chunk_valid[1]), .chunk_ready(chunk_ready[1]),
    .chunk_train(chunk_train[1]), .chunk_query(chunk_query[1]), .chunk_type(chunk_type[1]),
    .dist_valid(dist_valid[1]), .dist_ready(dist_ready[1]), .distance(distance[1]),
    .data_type(data_type[1]), .sat(sat[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int feat(input int id);
    return (id == 0) ? 16 : 10;
  endfunction

  function automatic exp_t model(input int id, input int metric, input int label);
    exp_t   r;
    longint total;
    total = 0;
    for (int f = 0; f < feat(id); f++) begin
      longint d = longint'(train_vec[f]) - longint'(query_vec[f]);
      total += (metric == 1) ? ((d < 0) ? -d : d) : d * d;
    end
    r.sat       = (total > 65535);
    r.distance  = r.sat ? 16'hFFFF : 16'(total);
    r.data_type = 4'(label);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int id, input longint actual,
                             input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s dut=%0d actual=%0d expected=%0d", name, id, actual, expected);
    end
  endtask

  // Downstream model: holds dist_ready low for ready_delay cycles of each result.
  initial begin
    for (int i = 0; i < 2; i++) begin
      dist_ready[i] = 1'b0;
      wait_cnt[i]   = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (!dist_valid[i]) begin
          dist_ready[i] = 1'b0;
          wait_cnt[i]   = 0;
        end else if (wait_cnt[i] < ready_delay) begin
          dist_ready[i] = 1'b0;
          wait_cnt[i]++;
        end else begin
          dist_ready[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: checks held outputs while stalled and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && hold_pending[i]) begin
        checkOutput("valid_held", i, dist_valid[i], 1);
        checkOutput("distance_stable", i, distance[i], held[i].distance);
        checkOutput("sat_stable", i, sat[i], held[i].sat);
        checkOutput("type_stable", i, data_type[i], held[i].data_type);
      end
      if (!rst && dist_valid[i] && dist_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          checkOutput("unexpected_result", i, 1, 0);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          checkOutput("distance", i, distance[i], e.distance);
          checkOutput("sat", i, sat[i], e.sat);
          checkOutput("data_type", i, data_type[i], e.data_type);
        end
      end
      hold_pending[i]   = !rst && dist_valid[i] && !dist_ready[i];
      held[i].distance  = distance[i];
      held[i].sat       = sat[i];
      held[i].data_type = data_type[i];
    end
  end

  task automatic fillConst(input int tval, input int qval);
    for (int f = 0; f < 16; f++) begin
      train_vec[f] = tval;
      query_vec[f] = qval;
    end
  endtask

  task automatic fillRandom();
    for (int f = 0; f < 16; f++) begin
      train_vec[f] = int'($urandom_range(255)) - 128;
      query_vec[f] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic driveChunk(input int id, input int c);
    for (int l = 0; l < 4; l++) begin
      int f;
      f = c * 4 + l;
      chunk_train[id][l*8 +: 8] = train_vec[f][7:0];
      chunk_query[id][l*8 +: 8] = query_vec[f][7:0];
    end
  endtask

  task automatic waitIdle(input int id);
    int guard;
    guard = 0;
    while (busy[id] && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("idle_wait", id, busy[id], 0);
  endtask

  task automatic checkResetValues(input int id);
    checkOutput("rst_chunk_ready", id, chunk_ready[id], 0);
    checkOutput("rst_dist_valid", id, dist_valid[id], 0);
    checkOutput("rst_distance", id, distance[id], 0);
    checkOutput("rst_data_type", id, data_type[id], 0);
    checkOutput("rst_sat", id, sat[id], 0);
    checkOutput("rst_busy", id, busy[id], 0);
  endtask

  task automatic applyStimulus(input int id, input int metric, input int label,
                               input int early_label, input bit gaps, input bit spurious);
    int nch;
    int guard;
    int lat;
    bit accepted;
    nch = (feat(id) + 3) / 4;
    waitIdle(id);
    exp_q[id].push_back(model(id, metric, label));
    start[id]      = 1'b1;
    metric_sel[id] = metric[0];
    @(posedge clk);
    #1;
    start[id] = 1'b0;
    for (int c = 0; c < nch; c++) begin
      if (gaps) begin
        while ($urandom_range(2) == 0) begin
          chunk_valid[id] = 1'b0;
          chunk_train[id] = $urandom;
          chunk_query[id] = $urandom;
          chunk_type[id]  = 4'($urandom);
          @(posedge clk);
          #1;
        end
      end
      chunk_valid[id] = 1'b1;
      driveChunk(id, c);
      chunk_type[id] = (c == nch - 1) ? 4'(label) : 4'(early_label);
      if (spurious && c == 1) begin
        start[id]      = 1'b1;
        metric_sel[id] = !metric[0];
      end
      guard = 0;
      do begin
        accepted = chunk_ready[id];
        @(posedge clk);
        #1;
        guard++;
      end while (!accepted && guard < 50);
      start[id]      = 1'b0;
      metric_sel[id] = metric[0];
      if (!accepted) checkOutput("beat_accept_timeout", id, 0, 1);
    end
    chunk_valid[id] = 1'b0;
    chunk_type[id]  = 4'(early_label);
    checkOutput("ready_low_after_last", id, chunk_ready[id], 0);
    lat = 1;
    while (!dist_valid[id] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", id, lat, 3);
    if (spurious) begin
      guard = 0;
      while (dist_valid[id] && guard < 50) begin
        start[id]      = 1'b1;
        metric_sel[id] = !metric[0];
        @(posedge clk);
        #1;
        guard++;
      end
      start[id]      = 1'b0;
      metric_sel[id] = 1'b0;
      checkOutput("idle_after_handshake", id, busy[id], 0);
    end
  endtask

  task automatic resetMidRun(input int id);
    fillConst(3, 0);
    waitIdle(id);
    start[id]      = 1'b1;
    metric_sel[id] = 1'b0;
    @(posedge clk);
    #1;
    start[id] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chunk_valid[id] = 1'b1;
      driveChunk(id, c);
      @(posedge clk);
      #1;
    end
    chunk_valid[id] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetValues(id);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    ready_delay = 0;
    rst         = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i]        = 1'b0;
      metric_sel[i]   = 1'b0;
      chunk_valid[i]  = 1'b0;
      chunk_train[i]  = '0;
      chunk_query[i]  = '0;
      chunk_type[i]   = '0;
      hold_pending[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkResetValues(0);
    checkResetValues(1);
    rst = 1'b0;

    $display("[TB] directed vectors");
    fillConst(3, 0);
    applyStimulus(0, 0, 5, 2, 0, 0);
    applyStimulus(0, 1, 5, 2, 0, 0);
    fillConst(127, -128);
    applyStimulus(0, 0, 9, 1, 0, 0);
    applyStimulus(0, 1, 9, 1, 0, 0);

    $display("[TB] masked tail lanes");
    for (int f = 0; f < 16; f++) begin
      train_vec[f] = (f < 10) ? 1 : -100;
      query_vec[f] = (f < 10) ? 0 : 100;
    end
    applyStimulus(1, 0, 6, 3, 0, 0);
    applyStimulus(1, 1, 6, 3, 0, 0);

    $display("[TB] gaps, stalled output, ignored starts");
    ready_delay = 5;
    for (int id = 0; id < 2; id++) begin
      fillRandom();
      applyStimulus(id, id, 10 + id, 4, 1, 1);
    end
    ready_delay = 0;

    $display("[TB] reset mid-run");
    waitIdle(0);
    resetMidRun(0);
    fillConst(3, 0);
    applyStimulus(0, 0, 7, 2, 0, 0);

    $display("[TB] random vectors");
    for (int n = 0; n < 16; n++) begin
      int id;
      id          = int'($urandom_range(1));
      ready_delay = int'($urandom_range(3));
      fillRandom();
      applyStimulus(id, int'($urandom_range(1)), int'($urandom_range(15)),
                    int'($urandom_range(15)), bit'($urandom_range(1)), bit'($urandom_range(1)));
    end

    waitIdle(0);
    waitIdle(1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 0, exp_q[0].size(), 0);
    checkOutput("scoreboard_empty", 1, exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
